cbus_arbiter: RTL and testbench



---
 rtl/common.sv | 41 ++++
 rtl/rr_pick.sv | 33 +++
 rtl/cbus_arbiter.sv | 88 ++++++++
 tb/tb_cbus_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared cbus transaction types used by the cache layer and the memory bridge.
// Pure type/constant definitions; no logic, no latency.
package common;

    // Encoded as beats-1, so MLEN256 is an 8-bit all-ones length.
    typedef enum logic [7:0] {
        MLEN1   = 8'd0,
        MLEN2   = 8'd1,
        MLEN4   = 8'd3,
        MLEN8   = 8'd7,
        MLEN16  = 8'd15,
        MLEN32  = 8'd31,
        MLEN64  = 8'd63,
        MLEN128 = 8'd127,
        MLEN256 = 8'd255
    } cbus_len_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [2:0]  size;
        cbus_len_t   len;
        axi_burst_t  burst;
        logic [7:0]  strobe;
        logic [63:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin chooser: first valid index strictly after last_grant, searching cyclically.
// Purely combinational; no state, no backpressure.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] above;
    logic [IDX_W-1:0]   idx_hi;
    logic [IDX_W-1:0]   idx_lo;

    always_comb begin
        above  = '0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            above[i] = (i > int'(last_grant));
        end
        // Downward scans leave the lowest set index; indices above last_grant take priority over the wrap.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid[i] && above[i]) idx_hi = IDX_W'(i);
            if (valid[i])             idx_lo = IDX_W'(i);
        end
        any = |valid;
        idx = (|(valid & above)) ? idx_hi : idx_lo;
    end

endmodule

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: grants the shared cbus port round-robin and holds it for a whole burst.
// Grant one cycle after a request seen in IDLE; responses pass through combinationally; losers wait holding valid.
module cbus_arbiter
    import common::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireqs  [NUM_REQ],
    output cbus_resp_t iresps [NUM_REQ],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;
    localparam type state_t = state_e;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     sel;
    logic [IDX_W-1:0]     last_grant;
    logic [NUM_REQ-1:0]   req_vld;
    logic                 pick_any;
    logic [IDX_W-1:0]     pick_idx;
    logic                 burst_done;

    always_comb begin
        req_vld = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vld[i] = ireqs[i].valid;
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid      (req_vld),
        .last_grant (last_grant),
        .any        (pick_any),
        .idx        (pick_idx)
    );

    assign burst_done = (state == BUSY) && oresp.ready && oresp.last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_any) sel <= pick_idx;
            if (burst_done)                last_grant <= sel;
        end
    end

    // Burst end comes only from the bridge's last beat; the arbiter never counts len.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any)   state_nxt = BUSY;
            BUSY:    if (burst_done) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            iresps[i] = '0;
        end
        if (state == BUSY) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (sel == IDX_W'(i)) begin
                    oreq      = ireqs[i];
                    iresps[i] = oresp;
                end
            end
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: a 2-requester instance for the main scenarios and a 3-requester one for wrap-around.
// Inputs change 1 time unit after posedge; outputs are compared at negedge.
module tb_cbus_arbiter;
    import common::*;

    logic       clk;
    logic       reset;
    cbus_req_t  ireqs   [2];
    cbus_resp_t iresps  [2];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    cbus_req_t  ireqs3  [3];
    cbus_resp_t iresps3 [3];
    cbus_req_t  oreq3;
    cbus_resp_t oresp3;

    cbus_req_t  req_tab [3];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] pend;

    cbus_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp)
    );

    cbus_arbiter #(.NUM_REQ(3)) dut3 (
        .clk    (clk),
        .reset  (reset),
        .ireqs  (ireqs3),
        .iresps (iresps3),
        .oreq   (oreq3),
        .oresp  (oresp3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // A requester must hold valid from assertion until it has seen ready && last.
    always @(posedge clk) begin
        if (reset) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i]) assert (ireqs[i].valid) else $error("requester %0d dropped valid while pending", i);
                pend[i] <= ireqs[i].valid && !(iresps[i].ready && iresps[i].last);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cbus_req_t mk_req(input logic [31:0] a, input cbus_len_t l, input logic [7:0] strb);
        cbus_req_t r;
        r        = '0;
        r.valid  = 1'b1;
        r.addr   = a;
        r.len    = l;
        r.size   = 3'd3;
        r.burst  = AXI_BURST_INCR;
        r.strobe = strb;
        return r;
    endfunction

    function automatic cbus_resp_t mk_beat(input int who, input int k, input logic last);
        cbus_resp_t r;
        r.ready = 1'b1;
        r.last  = last;
        r.data  = {8'(who), 24'h5A5A5A, 32'(k)};
        return r;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) ireqs[i] = '0;
        for (int i = 0; i < 3; i++) ireqs3[i] = '0;
        oresp  = '0;
        oresp3 = '0;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Bridge idles with junk on data so a leaky IDLE response path shows up.
    task automatic idle_cycle(input string tag);
        oresp = '{ready: 1'b0, last: 1'b0, data: 64'hDEAD_BEEF_0BAD_F00D};
        @(negedge clk);
        check_eq({tag, "_oreq"}, 128'(oreq), 128'd0);
        check_eq({tag, "_resp0"}, 128'(iresps[0]), 128'd0);
        check_eq({tag, "_resp1"}, 128'(iresps[1]), 128'd0);
    endtask

    // Entered just after the posedge of the expected grant cycle; runs nrun beats of an nbeats burst.
    task automatic do_burst(input int who, input int nbeats, input int nrun, input int late_at);
        cbus_resp_t beat;
        for (int k = 0; k < nrun; k++) begin
            if (k > 0) tick();
            beat  = mk_beat(who, k, k == nbeats - 1);
            oresp = beat;
            if (k == late_at) ireqs[1] = req_tab[1];
            @(negedge clk);
            check_eq($sformatf("oreq_r%0d_b%0d", who, k), 128'(oreq), 128'(req_tab[who]));
            check_eq($sformatf("own_r%0d_b%0d", who, k), 128'(iresps[who]), 128'(beat));
            check_eq($sformatf("other_r%0d_b%0d", who, k), 128'(iresps[1 - who]), 128'd0);
        end
    endtask

    initial begin
        req_tab[0] = mk_req(32'h8000_0800, MLEN256, 8'hFF);
        req_tab[1] = mk_req(32'h9000_1000, MLEN8, 8'h0F);
        req_tab[2] = mk_req(32'hA000_0000, MLEN4, 8'hF0);
        reset = 1'b1;
        clear_inputs();

        // Reset state, then a single 256-beat read from requester 0.
        do_reset();
        ireqs[0] = req_tab[0];
        @(negedge clk);
        check_eq("rst_oreq", 128'(oreq), 128'd0);
        check_eq("rst_resp0", 128'(iresps[0]), 128'd0);
        check_eq("rst_resp1", 128'(iresps[1]), 128'd0);
        check_eq("rst_last_grant", 128'(dut.last_grant), 128'd1);
        check_eq("rst_sel", 128'(dut.sel), 128'd0);
        tick();
        do_burst(0, 256, 256, -1);
        tick();
        ireqs[0].valid = 1'b0;
        idle_cycle("single_after_last");
        check_eq("single_last_grant", 128'(dut.last_grant), 128'd0);

        // Tie straight out of reset: requester 0 first, requester 1 at last+2.
        do_reset();
        ireqs[0] = req_tab[0];
        ireqs[1] = req_tab[1];
        tick();
        do_burst(0, 4, 4, -1);
        tick();
        ireqs[0].valid = 1'b0;
        idle_cycle("tie_gap");
        tick();
        do_burst(1, 4, 4, -1);
        tick();
        ireqs[1].valid = 1'b0;
        idle_cycle("tie_end");

        // Continuous contention: strict alternation with one idle cycle between bursts.
        do_reset();
        ireqs[0] = req_tab[0];
        ireqs[1] = req_tab[1];
        for (int b = 0; b < 6; b++) begin
            tick();
            do_burst(b % 2, 3, 3, -1);
            tick();
            if (b == 5) ireqs[1].valid = 1'b0;
            idle_cycle($sformatf("cont_gap%0d", b));
        end

        // Late arrival at beat 100 of requester 0's burst.
        do_reset();
        ireqs[0] = req_tab[0];
        tick();
        do_burst(0, 256, 256, 100);
        tick();
        ireqs[0].valid = 1'b0;
        idle_cycle("late_gap");
        tick();
        do_burst(1, 2, 2, -1);
        tick();
        ireqs[1].valid = 1'b0;
        idle_cycle("late_end");

        // Reset at beat 10: arbiter back to IDLE next cycle with reset pointers.
        do_reset();
        ireqs[0] = req_tab[0];
        tick();
        do_burst(0, 256, 10, -1);
        tick();
        reset = 1'b1;
        ireqs[0].valid = 1'b0;
        oresp = mk_beat(0, 10, 1'b0);
        tick();
        reset = 1'b0;
        oresp = '0;
        ireqs[0] = req_tab[0];
        ireqs[1] = req_tab[1];
        @(negedge clk);
        check_eq("mid_rst_oreq", 128'(oreq), 128'd0);
        check_eq("mid_rst_resp0", 128'(iresps[0]), 128'd0);
        check_eq("mid_rst_resp1", 128'(iresps[1]), 128'd0);
        check_eq("mid_rst_last_grant", 128'(dut.last_grant), 128'd1);
        tick();
        do_burst(0, 2, 2, -1);
        tick();
        ireqs[0].valid = 1'b0;
        idle_cycle("mid_rst_gap");
        tick();
        do_burst(1, 2, 2, -1);

        // Three requesters: {0,2} after last_grant=0 picks 2, then {0,1,2} wraps to 0.
        do_reset();
        ireqs3[0] = req_tab[0];
        tick();
        oresp3 = '{ready: 1'b1, last: 1'b1, data: 64'h1111};
        @(negedge clk);
        check_eq("w_first_oreq", 128'(oreq3), 128'(req_tab[0]));
        check_eq("w_first_resp0", 128'(iresps3[0].data), 128'h1111);
        tick();
        oresp3 = '0;
        ireqs3[2] = req_tab[2];
        @(negedge clk);
        check_eq("w_gap1_oreq", 128'(oreq3), 128'd0);
        check_eq("w_gap1_last_grant", 128'(dut3.last_grant), 128'd0);
        tick();
        oresp3 = '{ready: 1'b1, last: 1'b1, data: 64'h2222};
        @(negedge clk);
        check_eq("w_pick2_oreq", 128'(oreq3), 128'(req_tab[2]));
        check_eq("w_pick2_resp2", 128'(iresps3[2]), 128'(oresp3));
        check_eq("w_pick2_resp0", 128'(iresps3[0]), 128'd0);
        check_eq("w_pick2_resp1", 128'(iresps3[1]), 128'd0);
        tick();
        oresp3 = '0;
        ireqs3[1] = req_tab[1];
        @(negedge clk);
        check_eq("w_gap2_oreq", 128'(oreq3), 128'd0);
        tick();
        oresp3 = '{ready: 1'b1, last: 1'b1, data: 64'h3333};
        @(negedge clk);
        check_eq("w_pick0_oreq", 128'(oreq3), 128'(req_tab[0]));
        check_eq("w_pick0_resp0", 128'(iresps3[0]), 128'(oresp3));
        check_eq("w_pick0_resp2", 128'(iresps3[2]), 128'd0);

        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
